hex_display_arbiter: RTL and testbench
======================================

Name: hex_display_arbiter

Overview:
Shares the single 16-bit hex-digit display PIO between two requesters. A round-robin arbiter accepts one 16-bit display value per grant and issues a single-cycle Avalon-MM write to the PIO's s1 slave at address 0. It then holds ownership for a programmable minimum dwell time so each value stays visible before the next update. The block sits between software/hardware value producers and the hex-digit PIO slave port.

Parameters:
HOLD_CYCLES, 1000, minimum clocks after a write before the next grant (0 = no dwell)
CNT_W, 32, width of the dwell counter; must hold HOLD_CYCLES-1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a value to display
req0_data  input  16  requester 0 value (4 hex digits)
req0_ready  output  1  requester 0 value accepted this cycle
req1_valid  input  1  requester 1 has a value to display
req1_data  input  16  requester 1 value
req1_ready  output  1  requester 1 value accepted this cycle
avm_chipselect  output  1  PIO slave chipselect
avm_address  output  2  PIO slave address, always 0
avm_write_n  output  1  PIO slave write strobe, active-low
avm_writedata  output  32  {16'b0, latched value}
owner  output  1  requester that won the most recent grant
busy  output  1  high in WRITE or HOLD

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE, avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0, req*_ready 0, busy 0, owner 1. Last-grant pointer is 1, so requester 0 wins the first contention.
- States: IDLE, WRITE, HOLD.
- IDLE:
  - If exactly one req*_valid is high, grant it.
  - If both are high, grant the requester not equal to the last-grant pointer.
  - req*_ready is combinational: high only in IDLE, for the granted requester, while its valid is high. At most one ready is high per cycle.
  - On handshake (valid & ready): capture the data into the value register, update owner and the last-grant pointer, and go to WRITE.
  - If no valid is high, stay in IDLE and drive no ready.
- WRITE:
  - Exactly one cycle with avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata={16'b0, value}.
  - If HOLD_CYCLES=0, go to IDLE. Otherwise load the counter with HOLD_CYCLES-1 and go to HOLD.
- HOLD:
  - Chipselect is deasserted and write_n=1. The counter decrements each cycle; at 0, go to IDLE.
  - Both readies stay low, including for the current owner. New values wait; valid is held by the requester.
- Outside WRITE: avm_chipselect=0 and avm_write_n=1. avm_writedata keeps the last value.
- Latency:
  - Handshake in cycle N produces the write in cycle N+1.
  - The earliest next handshake is cycle N+2+HOLD_CYCLES.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A lone requester can be granted back-to-back, subject to the dwell time.
- A valid dropped before ready is simply not served; no state change.
- Reset asserted in WRITE or HOLD: the next cycle is IDLE with reset values, and no write strobe appears after reset. The value register clears to 0.
- The PIO has no wait-request, so a write completes in one cycle. No read access is issued.

Test Plan:
- Reset, then req0_valid=1 with data=16'h1234 (HOLD_CYCLES=4) -> req0_ready high in the same cycle. One cycle later: chipselect=1, write_n=0, address=0, writedata=32'h0000_1234. busy high for 5 cycles total, then IDLE.
- Both valid from reset, data0=16'hAAAA and data1=16'h5555, held -> writes in order AAAA, 5555, AAAA, 5555. Strobes are spaced exactly 6 cycles apart; owner toggles 0,1,0,1.
- req1 asserted during req0's HOLD -> req1_ready stays low until the counter reaches 0. It is granted on the first IDLE cycle and the write follows on the next cycle.
- HOLD_CYCLES=0 with req0 continuously valid, values 1,2,3 -> strobes on every second cycle: handshake then write, no dwell.
- Reset pulsed in the WRITE cycle -> no strobe on the following cycle. All outputs return to reset values; the next contention grants req0 first.
- req0_valid pulsed for one cycle during HOLD and then dropped -> no handshake and no write. The last written value stays on avm_writedata.

Source files
------------

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter
//
// Shares the single 16-bit hex-digit display PIO between two requesters. A
// round-robin arbiter accepts one display value per grant, issues a single-cycle
// Avalon-MM write to the PIO s1 slave at address 0, then holds ownership for
// HOLD_CYCLES clocks so the value stays visible before the next update.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   req0_valid/data  requester 0 value offer (16 bits, 4 hex digits)
//   req0_ready       requester 0 value accepted this cycle
//   req1_valid/data  requester 1 value offer
//   req1_ready       requester 1 value accepted this cycle
//   avm_chipselect   PIO slave chipselect, high only in the write cycle
//   avm_address      PIO slave address, always 0
//   avm_write_n      PIO slave write strobe, active-low
//   avm_writedata    {16'b0, last accepted value}
//   owner            requester that won the most recent grant
//   busy             high while writing or dwelling

module hex_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        avm_chipselect,
    output logic [1:0]  avm_address,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    output logic        owner,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // Dwell counter load value; unused when there is no dwell.
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      value_q, value_d;
    // The last-grant pointer and the owner output always move together, so a
    // single register serves both.
    logic             last_q, last_d;

    logic             gnt0, gnt1;

    // Grant selection: only in IDLE; on contention the requester that did not
    // win last time goes first.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // A grant is a handshake because ready only rises with valid.
                if (gnt0 || gnt1) begin
                    value_d = gnt1 ? req1_data : req0_data;
                    last_d  = gnt1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (HOLD_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            value_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            last_q  <= last_d;
        end
    end

    // The PIO has no wait-request, so the strobe is simply the WRITE state.
    assign avm_chipselect = (state_q == WRITE);
    assign avm_write_n    = (state_q != WRITE);
    assign avm_address    = 2'b00;
    assign avm_writedata  = {16'h0000, value_q};
    assign owner          = last_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: DUT 0 with HOLD_CYCLES=4, DUT 1 with
// HOLD_CYCLES=0. A timestamp-based model (handshake cycle, write cycle,
// free-again cycle) predicts every output on every cycle; directed phases add
// hand-computed literal expectations.

module tb_hex_display_arbiter;

    localparam int unsigned HA = 4;
    localparam int unsigned HB = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, v0, v1;
    logic [15:0] d0 [2];
    logic [15:0] d1 [2];
    logic [1:0]  rdy0, rdy1, cs, wn, own, bsy;
    logic [1:0]  adr [2];
    logic [31:0] wd [2];

    hex_display_arbiter #(.HOLD_CYCLES(HA), .CNT_W(32)) u_dut_a (
        .clk(clk), .reset(rst[0]),
        .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(rdy0[0]),
        .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(rdy1[0]),
        .avm_chipselect(cs[0]), .avm_address(adr[0]), .avm_write_n(wn[0]),
        .avm_writedata(wd[0]), .owner(own[0]), .busy(bsy[0])
    );

    hex_display_arbiter #(.HOLD_CYCLES(HB), .CNT_W(8)) u_dut_b (
        .clk(clk), .reset(rst[1]),
        .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(rdy0[1]),
        .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(rdy1[1]),
        .avm_chipselect(cs[1]), .avm_address(adr[1]), .avm_write_n(wn[1]),
        .avm_writedata(wd[1]), .owner(own[1]), .busy(bsy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit   [1:0]  minit = 2'b00;
    int          free_at [2];
    int          write_at [2];
    logic [15:0] mval [2];
    logic [1:0]  mlast;

    function automatic int hold_of(input int k);
        return (k == 0) ? int'(HA) : int'(HB);
    endfunction

    // {grant1, grant0} the model expects in the current cycle
    function automatic logic [1:0] exp_gnt(input int k);
        logic idle, g0, g1;
        idle = minit[k] && (cyc >= free_at[k]);
        g0 = idle && v0[k] && (!v1[k] || mlast[k]);
        g1 = idle && v1[k] && (!v0[k] || !mlast[k]);
        return {g1, g0};
    endfunction

    always @(posedge clk) begin : p_model
        logic [1:0] g;
        for (int k = 0; k < 2; k++) begin
            g = exp_gnt(k);
            if (rst[k]) begin
                minit[k]    = 1'b1;
                free_at[k]  = cyc + 1;
                write_at[k] = -1;
                mval[k]     = 16'h0000;
                mlast[k]    = 1'b1;
            end else if (g != 2'b00) begin
                mval[k]     = g[1] ? d1[k] : d0[k];
                mlast[k]    = g[1];
                write_at[k] = cyc + 1;
                free_at[k]  = cyc + 2 + hold_of(k);
            end
        end
        cyc++;
    end

    // Strobe logs for the directed literal checks
    int          sc_a [$];
    logic [15:0] sd_a [$];
    logic        so_a [$];
    int          sc_b [$];

    bit chk_en = 1'b0;

    always @(negedge clk) begin : p_compare
        logic [1:0] g;
        logic       wr;
        if (cs[0] === 1'b1 && wn[0] === 1'b0) begin
            sc_a.push_back(cyc);
            sd_a.push_back(wd[0][15:0]);
            so_a.push_back(own[0]);
        end
        if (cs[1] === 1'b1 && wn[1] === 1'b0) sc_b.push_back(cyc);
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                if (minit[k]) begin
                    g  = exp_gnt(k);
                    wr = (cyc == write_at[k]);
                    chk($sformatf("m%0d_ready0", k), rdy0[k], g[0]);
                    chk($sformatf("m%0d_ready1", k), rdy1[k], g[1]);
                    chk($sformatf("m%0d_cs", k), cs[k], wr);
                    chk($sformatf("m%0d_write_n", k), wn[k], !wr);
                    chk($sformatf("m%0d_addr", k), adr[k], 0);
                    chk($sformatf("m%0d_wdata", k), wd[k], {16'h0000, mval[k]});
                    chk($sformatf("m%0d_owner", k), own[k], mlast[k]);
                    chk($sformatf("m%0d_busy", k), bsy[k], cyc < free_at[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int bc, n, nb;
        rst = 2'b11; v0 = 2'b00; v1 = 2'b00;
        for (int k = 0; k < 2; k++) begin
            d0[k] = 16'h0000;
            d1[k] = 16'h0000;
        end
        chk_en = 1'b1;
        step();
        step();

        // Phase 1: single request, dwell 4
        rst = 2'b00;
        v0[0] = 1'b1; d0[0] = 16'h1234;
        @(negedge clk);
        chk("p1_reset_owner", own[0], 1'b1);
        chk("p1_ready0", rdy0[0], 1'b1);
        step();
        v0[0] = 1'b0;
        @(negedge clk);
        chk("p1_cs", cs[0], 1'b1);
        chk("p1_write_n", wn[0], 1'b0);
        chk("p1_wdata", wd[0], 32'h0000_1234);
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bsy[0] !== 1'b1) break;
            bc++;
            @(negedge clk);
        end
        chk("p1_busy_len", bc, 5);

        // Phase 2: continuous contention
        step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        sc_a.delete(); sd_a.delete(); so_a.delete();
        v0[0] = 1'b1; d0[0] = 16'hAAAA;
        v1[0] = 1'b1; d1[0] = 16'h5555;
        repeat (30) step();
        v0[0] = 1'b0; v1[0] = 1'b0;
        chk("p2_nwrites_ge4", sc_a.size() >= 4, 1'b1);
        if (sc_a.size() >= 4) begin
            chk("p2_data0", sd_a[0], 16'hAAAA);
            chk("p2_data1", sd_a[1], 16'h5555);
            chk("p2_data2", sd_a[2], 16'hAAAA);
            chk("p2_data3", sd_a[3], 16'h5555);
            chk("p2_owner0", so_a[0], 1'b0);
            chk("p2_owner1", so_a[1], 1'b1);
            chk("p2_owner2", so_a[2], 1'b0);
            chk("p2_owner3", so_a[3], 1'b1);
            for (int i = 0; i < 3; i++)
                chk($sformatf("p2_gap%0d", i), sc_a[i+1] - sc_a[i], 6);
        end
        repeat (10) step();

        // Phase 3: req1 arrives during req0's dwell
        v0[0] = 1'b1; d0[0] = 16'h0BEE;
        @(negedge clk);
        chk("p3_ready0", rdy0[0], 1'b1);
        step();
        v0[0] = 1'b0;
        step();
        v1[0] = 1'b1; d1[0] = 16'hC0DE;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy1[0] === 1'b1) break;
            n++;
            step();
        end
        chk("p3_wait", n, 4);
        step();
        v1[0] = 1'b0;
        @(negedge clk);
        chk("p3_cs", cs[0], 1'b1);
        chk("p3_wdata", wd[0], 32'h0000_C0DE);
        repeat (8) step();

        // Phase 4: no dwell, values 1,2,3
        sc_b.delete();
        v0[1] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            d0[1] = 16'(i);
            @(negedge clk);
            chk("p4_ready0", rdy0[1], 1'b1);
            step();
            @(negedge clk);
            chk("p4_cs", cs[1], 1'b1);
            chk("p4_wdata", wd[1], 32'(i));
            step();
        end
        v0[1] = 1'b0;
        chk("p4_nwrites", sc_b.size(), 3);
        if (sc_b.size() == 3) begin
            chk("p4_gap0", sc_b[1] - sc_b[0], 2);
            chk("p4_gap1", sc_b[2] - sc_b[1], 2);
        end
        repeat (4) step();

        // Phase 5: reset during the write cycle
        v0[0] = 1'b1; d0[0] = 16'h7777;
        @(negedge clk);
        chk("p5_ready0", rdy0[0], 1'b1);
        step();
        v0[0] = 1'b0;
        rst[0] = 1'b1;
        @(negedge clk);
        chk("p5_cs_before", cs[0], 1'b1);
        step();
        rst[0] = 1'b0;
        @(negedge clk);
        chk("p5_cs_after", cs[0], 1'b0);
        chk("p5_write_n", wn[0], 1'b1);
        chk("p5_wdata", wd[0], 32'h0);
        chk("p5_owner", own[0], 1'b1);
        chk("p5_busy", bsy[0], 1'b0);
        step();
        v0[0] = 1'b1; d0[0] = 16'h0101;
        v1[0] = 1'b1; d1[0] = 16'h0202;
        @(negedge clk);
        chk("p5_first_ready0", rdy0[0], 1'b1);
        chk("p5_first_ready1", rdy1[0], 1'b0);
        step();
        v0[0] = 1'b0; v1[0] = 1'b0;
        repeat (8) step();

        // Phase 6: valid pulsed during dwell is not served
        v1[0] = 1'b1; d1[0] = 16'h4321;
        @(negedge clk);
        step();
        v1[0] = 1'b0;
        step();
        nb = sc_a.size();
        v0[0] = 1'b1; d0[0] = 16'h9999;
        step();
        v0[0] = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("p6_wdata", wd[0], 32'h0000_4321);
        chk("p6_no_write", sc_a.size(), nb);
        step();

        // Phase 7: random traffic with occasional resets
        repeat (3000) begin
            step();
            for (int k = 0; k < 2; k++) begin
                rst[k] = ($urandom_range(0, 199) == 0);
                v0[k]  = ($urandom_range(0, 3) != 0);
                v1[k]  = ($urandom_range(0, 3) != 0);
                d0[k]  = 16'($urandom);
                d1[k]  = 16'($urandom);
            end
        end
        step();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
